// File: rtl/truth_table_sweeper.sv
// Sweeps every N_IN-bit pattern into a combinational block and MISR-compresses its sampled responses.
// Optional macro SWEEP_CHECK_EN adds exp_sig input and sticky pass/fail outputs.
module truth_table_sweeper #(
    parameter int               N_IN   = 2,
    parameter int               N_OUT  = 2,
    parameter int               DWELL  = 100,
    parameter int               SETTLE = 100,
    parameter int               REPEAT = 1,
    parameter int               SIG_W  = 16,
    parameter logic [SIG_W-1:0] POLY   = 16'h1021
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic              abort,
    output logic [N_IN-1:0]   pattern,
    input  logic [N_OUT-1:0]  resp,
    output logic              busy,
    output logic              done,
    output logic              vec_valid,
    output logic [N_IN-1:0]   vec_idx,
    output logic [N_OUT-1:0]  vec_resp,
`ifdef SWEEP_CHECK_EN
    input  logic [SIG_W-1:0]  exp_sig,
    output logic              pass,
    output logic              fail,
`endif
    output logic [SIG_W-1:0]  sig
);

    localparam logic [1:0] S_IDLE   = 2'd0;
    localparam logic [1:0] S_SETTLE = 2'd1;
    localparam logic [1:0] S_DRIVE  = 2'd2;
    localparam logic [1:0] S_DONE   = 2'd3;

    localparam int DW_W = (DWELL  > 1) ? $clog2(DWELL)  : 1;
    localparam int ST_W = (SETTLE > 1) ? $clog2(SETTLE) : 1;
    localparam int PS_W = (REPEAT > 1) ? $clog2(REPEAT) : 1;

    localparam logic [DW_W-1:0] DWELL_LAST  = DW_W'(DWELL - 1);
    localparam logic [ST_W-1:0] SETTLE_LAST = ST_W'((SETTLE > 0) ? SETTLE - 1 : 0);
    localparam logic [PS_W-1:0] PASS_LAST   = PS_W'(REPEAT - 1);

    logic [1:0]       r_state;
    logic [N_IN-1:0]  r_pattern;
    logic [SIG_W-1:0] r_sig;
    logic             r_busy;
    logic             r_done;
    logic             r_vec_valid;
    logic [N_IN-1:0]  r_vec_idx;
    logic [N_OUT-1:0] r_vec_resp;
    logic [DW_W-1:0]  r_dwell_cnt;
    logic [ST_W-1:0]  r_settle_cnt;
    logic [PS_W-1:0]  r_pass_cnt;

    logic [SIG_W-1:0] w_sig_next;
    logic             w_sample;
    logic             w_finish;

    assign w_sig_next = {r_sig[SIG_W-2:0], 1'b0}
                      ^ (r_sig[SIG_W-1] ? POLY : '0)
                      ^ SIG_W'(resp);
    // abort outranks a sample landing on the same edge
    assign w_sample   = (r_state == S_DRIVE) && !abort && (r_dwell_cnt == DWELL_LAST);
    assign w_finish   = w_sample && (&r_pattern) && (r_pass_cnt == PASS_LAST);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state      <= S_IDLE;
            r_pattern    <= '0;
            r_sig        <= '0;
            r_busy       <= 1'b0;
            r_done       <= 1'b0;
            r_vec_valid  <= 1'b0;
            r_vec_idx    <= '0;
            r_vec_resp   <= '0;
            r_dwell_cnt  <= '0;
            r_settle_cnt <= '0;
            r_pass_cnt   <= '0;
        end else begin
            r_done      <= 1'b0;
            r_vec_valid <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (start) begin
                        r_pattern    <= '0;
                        r_sig        <= '0;
                        r_dwell_cnt  <= '0;
                        r_settle_cnt <= '0;
                        r_pass_cnt   <= '0;
                        r_busy       <= 1'b1;
                        r_state      <= (SETTLE == 0) ? S_DRIVE : S_SETTLE;
                    end
                end
                S_SETTLE: begin
                    if (abort) begin
                        r_state   <= S_IDLE;
                        r_busy    <= 1'b0;
                        r_pattern <= '0;
                    end else if (r_settle_cnt == SETTLE_LAST) begin
                        r_state      <= S_DRIVE;
                        r_dwell_cnt  <= '0;
                        r_settle_cnt <= '0;
                    end else begin
                        r_settle_cnt <= r_settle_cnt + ST_W'(1);
                    end
                end
                S_DRIVE: begin
                    if (abort) begin
                        r_state   <= S_IDLE;
                        r_busy    <= 1'b0;
                        r_pattern <= '0;
                    end else if (w_sample) begin
                        r_sig       <= w_sig_next;
                        r_vec_valid <= 1'b1;
                        r_vec_idx   <= r_pattern;
                        r_vec_resp  <= resp;
                        r_dwell_cnt <= '0;
                        r_pattern   <= r_pattern + N_IN'(1);
                        if (w_finish) begin
                            r_state <= S_DONE;
                            r_busy  <= 1'b0;
                            r_done  <= 1'b1;
                        end else if (&r_pattern) begin
                            r_pass_cnt <= r_pass_cnt + PS_W'(1);
                        end
                    end else begin
                        r_dwell_cnt <= r_dwell_cnt + DW_W'(1);
                    end
                end
                S_DONE: begin
                    r_state <= S_IDLE;
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

`ifdef SWEEP_CHECK_EN
    logic r_pass;
    logic r_fail;

    // verdict is taken from the final signature as it is written, so it lines up with done
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_pass <= 1'b0;
            r_fail <= 1'b0;
        end else if ((r_state == S_IDLE) && start) begin
            r_pass <= 1'b0;
            r_fail <= 1'b0;
        end else if (w_finish) begin
            r_pass <= (w_sig_next == exp_sig);
            r_fail <= (w_sig_next != exp_sig);
        end
    end

    assign pass = r_pass;
    assign fail = r_fail;
`endif

    assign pattern   = r_pattern;
    assign sig       = r_sig;
    assign busy      = r_busy;
    assign done      = r_done;
    assign vec_valid = r_vec_valid;
    assign vec_idx   = r_vec_idx;
    assign vec_resp  = r_vec_resp;

endmodule

// File: tb/tb_truth_table_sweeper.sv
// Bench for truth_table_sweeper: spec scenarios plus randomized BUT tables and abort points vs a sample-list model.
module tb_truth_table_sweeper;

    localparam int NI = 2, NO = 2, DW = 4, ST = 2;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic start1 = 1'b0, abort1 = 1'b0, start2 = 1'b0, abort2 = 1'b0;
    logic [NI-1:0] pattern1, pattern2, idx1, idx2;
    logic [NO-1:0] resp1, resp2, vresp1, vresp2;
    logic busy1, done1, vld1, busy2, done2, vld2;
    logic [15:0] sig1, sig2;
    logic [NO-1:0] lut [4];

    always #5 clk = ~clk;

    assign resp1 = lut[pattern1];
    assign resp2 = lut[pattern2];

    truth_table_sweeper #(.N_IN(NI), .N_OUT(NO), .DWELL(DW), .SETTLE(ST), .REPEAT(1),
                          .SIG_W(16), .POLY(16'h1021)) dut (
        .clk(clk), .rst(rst), .start(start1), .abort(abort1), .pattern(pattern1),
        .resp(resp1), .busy(busy1), .done(done1), .vec_valid(vld1), .vec_idx(idx1),
        .vec_resp(vresp1), .sig(sig1));

    truth_table_sweeper #(.N_IN(NI), .N_OUT(NO), .DWELL(DW), .SETTLE(ST), .REPEAT(2),
                          .SIG_W(16), .POLY(16'h1021)) dut2 (
        .clk(clk), .rst(rst), .start(start2), .abort(abort2), .pattern(pattern2),
        .resp(resp2), .busy(busy2), .done(done2), .vec_valid(vld2), .vec_idx(idx2),
        .vec_resp(vresp2), .sig(sig2));

    int cur_sel = 0;
    logic m_busy, m_done, m_vld;
    logic [NI-1:0] m_pat, m_idx;
    logic [NO-1:0] m_resp;
    logic [15:0] m_sig;
    assign m_busy = (cur_sel != 0) ? busy2    : busy1;
    assign m_done = (cur_sel != 0) ? done2    : done1;
    assign m_vld  = (cur_sel != 0) ? vld2     : vld1;
    assign m_pat  = (cur_sel != 0) ? pattern2 : pattern1;
    assign m_idx  = (cur_sel != 0) ? idx2     : idx1;
    assign m_resp = (cur_sel != 0) ? vresp2   : vresp1;
    assign m_sig  = (cur_sel != 0) ? sig2     : sig1;

    int n_chk = 0, n_err = 0;
    int c_busy, c_done, c_last_busy, c_done_at, c_pat_err;
    logic [NI-1:0] q_idx [$];
    logic [NO-1:0] q_resp [$];

    // Signature after the first n samples of a sweep, straight from the MISR rule.
    function automatic logic [15:0] model_sig(input int n);
        int s = 0;
        for (int i = 0; i < n; i++)
            s = ((s * 2) % 65536) ^ ((s >= 32768) ? 32'h1021 : 32'h0) ^ int'(lut[i % 4]);
        return 16'(s);
    endfunction

    function automatic logic [NI-1:0] exp_pat(input int k);
        return (k < ST) ? '0 : NI'(((k - ST) / DW) % 4);
    endfunction

    // True when the first n recorded samples walk patterns 0,1,2,3,... with their table responses.
    function automatic bit samples_ok(input int n);
        if (q_idx.size() != n) return 1'b0;
        for (int i = 0; i < n; i++)
            if (q_idx[i] !== NI'(i % 4) || q_resp[i] !== lut[i % 4]) return 1'b0;
        return 1'b1;
    endfunction

    task automatic drive(input int sel, input logic s, input logic a);
        if (sel != 0) begin start2 = s; abort2 = a; end
        else begin start1 = s; abort1 = a; end
    endtask

    // Pulses start, then observes a fixed window of cycles (k=0 is the first cycle after the start edge).
    task automatic run_sweep(input int sel, input int win, input int start_at, input int abort_at,
                             input bit abort_with_start);
        q_idx.delete(); q_resp.delete();
        c_busy = 0; c_done = 0; c_last_busy = -1; c_done_at = -1; c_pat_err = 0;
        cur_sel = sel;
        @(negedge clk);
        drive(sel, 1'b1, abort_with_start);
        @(negedge clk);
        for (int k = 0; k < win; k++) begin
            if (m_busy) begin
                c_busy++; c_last_busy = k;
                if (m_pat !== exp_pat(k)) c_pat_err++;
            end
            if (m_vld) begin q_idx.push_back(m_idx); q_resp.push_back(m_resp); end
            if (m_done) begin c_done++; if (c_done_at < 0) c_done_at = k; end
            drive(sel, k == start_at, k == abort_at);
            @(negedge clk);
        end
        drive(sel, 1'b0, 1'b0);
    endtask

    task automatic test_reset;
        #3;
        n_chk++; if ({busy1, done1, vld1, pattern1, idx1, vresp1, sig1} !== '0) begin
            n_err++; $display("FAIL reset_hold: got busy=%b done=%b vld=%b pat=%0d sig=%h want all 0",
                              busy1, done1, vld1, pattern1, sig1); end
        repeat (2) @(negedge clk);
        rst = 1'b0;
        repeat (2) @(negedge clk);
        n_chk++; if ({busy1, done1, vld1, pattern1, sig1, busy2, sig2} !== '0) begin
            n_err++; $display("FAIL reset_release: got busy=%b pat=%0d sig=%h want idle zeros",
                              busy1, pattern1, sig1); end
    endtask

    task automatic test_identity;
        for (int i = 0; i < 4; i++) lut[i] = NO'(i);
        run_sweep(0, 24, -1, -1, 1'b0);
        n_chk++; if (c_busy != 18) begin n_err++;
            $display("FAIL ident_busy_len: got %0d want 18", c_busy); end
        n_chk++; if (c_done != 1 || c_done_at != c_last_busy + 1) begin n_err++;
            $display("FAIL ident_done: got count=%0d at=%0d want 1 at %0d", c_done, c_done_at, c_last_busy + 1); end
        n_chk++; if (!samples_ok(4)) begin n_err++;
            $display("FAIL ident_samples: got %0d samples want 4 with idx 0..3", q_idx.size()); end
        n_chk++; if (sig1 !== 16'h0003) begin n_err++;
            $display("FAIL ident_sig: got %h want 0003", sig1); end
        n_chk++; if (c_pat_err != 0 || pattern1 !== '0) begin n_err++;
            $display("FAIL ident_pattern: got %0d bad cycles, end pattern %0d want 0,0", c_pat_err, pattern1); end
    endtask

    task automatic test_repeat2;
        for (int i = 0; i < 4; i++) lut[i] = NO'(i);
        run_sweep(1, 40, -1, -1, 1'b0);
        n_chk++; if (c_busy != 34 || c_done != 1 || c_done_at != 34) begin n_err++;
            $display("FAIL rep2_len: got busy=%0d done=%0d at %0d want 34,1 at 34", c_busy, c_done, c_done_at); end
        n_chk++; if (!samples_ok(8)) begin n_err++;
            $display("FAIL rep2_samples: got %0d samples want 8", q_idx.size()); end
        n_chk++; if (sig2 !== 16'h0033) begin n_err++;
            $display("FAIL rep2_sig: got %h want 0033", sig2); end
    endtask

    task automatic test_logic_but;
        for (int i = 0; i < 4; i++) lut[i] = {NO'(i >> 1) & NO'(i & 1), 1'b0} | NO'(((i >> 1) ^ i) & 1);
        run_sweep(0, 24, -1, -1, 1'b0);
        n_chk++; if (q_resp.size() != 4 || q_resp[0] !== 2'b00 || q_resp[1] !== 2'b01
                     || q_resp[2] !== 2'b01 || q_resp[3] !== 2'b10) begin n_err++;
            $display("FAIL logic_resp: got %0d responses, want 00,01,01,10", q_resp.size()); end
        n_chk++; if (sig1 !== 16'h0004) begin n_err++;
            $display("FAIL logic_sig: got %h want 0004", sig1); end
    endtask

    task automatic test_abort;
        int ab;
        for (int i = 0; i < 4; i++) lut[i] = NO'(i);
        ab = ST + 3 * DW - 1;
        run_sweep(0, 24, -1, ab, 1'b0);
        n_chk++; if (q_idx.size() != 2 || c_done != 0) begin n_err++;
            $display("FAIL abort_events: got %0d samples %0d done want 2,0", q_idx.size(), c_done); end
        n_chk++; if (c_last_busy != ab) begin n_err++;
            $display("FAIL abort_busy: got last busy %0d want %0d", c_last_busy, ab); end
        n_chk++; if (sig1 !== 16'h0001 || pattern1 !== '0) begin n_err++;
            $display("FAIL abort_state: got sig=%h pat=%0d want 0001,0", sig1, pattern1); end
    endtask

    task automatic test_reset_mid;
        int guard = 0;
        for (int i = 0; i < 4; i++) lut[i] = NO'(i);
        cur_sel = 0;
        @(negedge clk); drive(0, 1'b1, 1'b0);
        @(negedge clk); drive(0, 1'b0, 1'b0);
        while (pattern1 !== 2'd2 && guard < 40) begin @(negedge clk); guard++; end
        n_chk++; if (pattern1 !== 2'd2) begin n_err++;
            $display("FAIL rstmid_reach: got pattern %0d want 2", pattern1); end
        #2 rst = 1'b1;
        #1;
        n_chk++; if ({busy1, done1, vld1, pattern1, idx1, vresp1, sig1} !== '0) begin n_err++;
            $display("FAIL rstmid_async: got busy=%b pat=%0d idx=%0d sig=%h want 0", busy1, pattern1, idx1, sig1); end
        @(negedge clk); rst = 1'b0;
        c_done = 0;
        repeat (20) begin @(negedge clk); if (done1 || busy1) c_done++; end
        n_chk++; if (c_done != 0) begin n_err++;
            $display("FAIL rstmid_quiet: got %0d busy/done cycles want 0", c_done); end
    endtask

    task automatic test_ignored_inputs;
        for (int i = 0; i < 4; i++) lut[i] = NO'(i);
        run_sweep(0, 24, 5, 18, 1'b0);
        n_chk++; if (c_busy != 18 || c_done != 1 || sig1 !== 16'h0003) begin n_err++;
            $display("FAIL start_busy: got busy=%0d done=%0d sig=%h want 18,1,0003", c_busy, c_done, sig1); end
        run_sweep(0, 24, -1, -1, 1'b1);
        n_chk++; if (c_busy != 18 || c_done != 1 || sig1 !== 16'h0003) begin n_err++;
            $display("FAIL start_abort: got busy=%0d done=%0d sig=%h want 18,1,0003", c_busy, c_done, sig1); end
    endtask

    task automatic test_random;
        int ab, n_exp, b_exp, d_exp;
        for (int it = 0; it < 8; it++) begin
            for (int i = 0; i < 4; i++) lut[i] = NO'($urandom_range(0, 3));
            ab = (it < 2) ? -1 : int'($urandom_range(0, 25));
            if (ab >= 0 && ab < ST + 4 * DW) begin
                n_exp = 0;
                for (int p = 0; p < 4; p++) if (ST + (p + 1) * DW - 1 < ab) n_exp++;
                b_exp = ab + 1; d_exp = 0;
            end else begin
                n_exp = 4; b_exp = ST + 4 * DW; d_exp = 1;
            end
            run_sweep(0, 26, -1, ab, 1'b0);
            n_chk++; if (c_busy != b_exp || c_done != d_exp || c_pat_err != 0) begin n_err++;
                $display("FAIL rand_flow[%0d]: got busy=%0d done=%0d paterr=%0d want %0d,%0d,0",
                         it, c_busy, c_done, c_pat_err, b_exp, d_exp); end
            n_chk++; if (!samples_ok(n_exp) || sig1 !== model_sig(n_exp)) begin n_err++;
                $display("FAIL rand_sig[%0d]: got %0d samples sig=%h want %0d sig=%h",
                         it, q_idx.size(), sig1, n_exp, model_sig(n_exp)); end
        end
    endtask

    initial begin
        for (int i = 0; i < 4; i++) lut[i] = '0;
        test_reset;
        test_identity;
        test_repeat2;
        test_logic_but;
        test_abort;
        test_reset_mid;
        test_ignored_inputs;
        test_random;
        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule

// File: doc/truth_table_sweeper.md
Name: truth_table_sweeper

Overview:
- Self-test sequencer for small combinational blocks under test (BUT).
- Drives every N_IN-bit input pattern in ascending order and holds each for a fixed dwell time.
- Samples the BUT response at the end of each dwell and compresses the responses into a MISR signature.
- Sits beside any BUT, feeding its inputs and reading its outputs; replaces hand-written exhaustive stimulus loops with synthesizable hardware.

Parameters:
- N_IN, 2, BUT input width; sweeps 2^N_IN patterns (1..16).
- N_OUT, 2, BUT output width; must be <= SIG_W.
- DWELL, 100, cycles each pattern is held (>=1).
- SETTLE, 100, cycles pattern 0 is held before the first counted vector (0 = skip).
- REPEAT, 1, number of full sweeps per start (>=1).
- SIG_W, 16, signature width.
- POLY, 16'h1021, MISR feedback polynomial (SIG_W bits).

Ports:
- clk  in  1  single clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- start  in  1  begin run; sampled only in IDLE.
- abort  in  1  terminate run; no done pulse.
- pattern  out  N_IN  stimulus to BUT inputs.
- resp  in  N_OUT  BUT outputs.
- busy  out  1  high while a run is active.
- done  out  1  one-cycle pulse when a run completes normally.
- vec_valid  out  1  one-cycle pulse when a response is sampled.
- vec_idx  out  N_IN  pattern that was sampled (valid with vec_valid).
- vec_resp  out  N_OUT  response that was sampled (valid with vec_valid).
- sig  out  SIG_W  running signature; holds after run ends.

Behaviour:
- Reset (async, any state): state=IDLE; pattern, vec_idx, vec_resp and sig = 0; busy, done and vec_valid = 0; all counters = 0.
- Registered outputs: everything changes on clk only, except during async reset.
- States are IDLE, SETTLE, DRIVE and DONE.
- IDLE:
  - On start=1: pattern=0, sig=0, dwell_cnt=0, pass_cnt=0, busy=1.
  - Next state is SETTLE, or DRIVE if SETTLE=0.
  - start while busy is ignored.
- SETTLE: count SETTLE cycles with pattern=0, no sampling, then enter DRIVE with dwell_cnt=0.
- DRIVE:
  - dwell_cnt counts 0..DWELL-1.
  - At dwell_cnt==DWELL-1, in the same edge:
    - sig <= (sig<<1) ^ (sig[SIG_W-1] ? POLY : 0) ^ zero-extended resp.
    - vec_valid=1, vec_idx=pattern, vec_resp=resp.
    - dwell_cnt=0; pattern increments.
  - Wrap: when pattern is all ones at sample, pattern wraps to 0 and pass_cnt increments.
  - If this was the last sweep (pass_cnt==REPEAT-1), go to DONE.
- DONE: busy=0, done=1 for one cycle, then IDLE. pattern returns to 0 and sig holds its final value.
- Run length: busy is high for exactly SETTLE + REPEAT*DWELL*2^N_IN cycles; done coincides with the first cycle busy is low.
- abort=1 in SETTLE or DRIVE:
  - Next edge goes to IDLE with busy=0, no done, pattern=0; sig keeps its partial value.
  - abort beats a same-cycle sample, so no vec_valid and no sig update.
  - abort in IDLE or DONE is ignored; DONE still pulses.
- start and abort together in IDLE: start wins.
- Reset mid-run: immediate return to the reset values; no done pulse.

Optional Feature:
- Macro: SWEEP_CHECK_EN.
- When defined:
  - Adds input exp_sig[SIG_W] and outputs pass[1] and fail[1].
  - On the DONE edge: pass = (sig==exp_sig), fail = inverse.
  - Both are sticky until the next accepted start or reset, which clears them to 0.
  - abort leaves both at 0.
- When undefined: these ports and their logic are absent; all other behaviour is identical.

Test Plan:
- N_IN=2, N_OUT=2, DWELL=4, SETTLE=2, REPEAT=1, identity BUT (resp=pattern), start pulse:
  - busy high for 18 cycles; done pulses once in the next cycle.
  - vec_valid fires 4 times with idx 0,1,2,3; final sig=16'h0003.
- Same config with REPEAT=2: busy high 34 cycles; 8 vec_valid pulses; final sig=16'h0033.
- BUT resp={a&b,a^b}, REPEAT=1:
  - vec_resp sequence 00,01,01,10; final sig=16'h0004.
  - With SWEEP_CHECK_EN and exp_sig=16'h0004: pass=1, fail=0. With exp_sig=16'h0005: pass=0, fail=1.
- abort asserted on the cycle of the 3rd sample:
  - only 2 vec_valid pulses; no done; busy low next cycle; sig=16'h0001; pattern=0.
- Reset asserted mid-DRIVE (pattern=2): all outputs zero immediately.
  - start pulsed while busy: ignored; run length and signature unchanged (16'h0003).
  - start and abort in the same IDLE cycle: run starts.
